// File: rtl/bell_pkg.sv
// Shared types and constants for the bell game round sequencer.
package bell_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEAL,
    S_WAIT,
    S_JUDGE,
    S_SCORE,
    S_GAP,
    S_OVER
  } state_t;

  localparam logic [1:0] P_NONE = 2'b00;
  localparam logic [1:0] P1     = 2'b01;
  localparam logic [1:0] P2     = 2'b10;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 as a mask over bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [2:0] card_num(input logic [2:0] v);
    return (v <= 3'd4) ? v + 3'd1 : v - 3'd4;
  endfunction

  // Signed running-total update, clamped to the 10-bit range.
  function automatic logic [9:0] sat_add(input logic [9:0] tot, input logic [7:0] d);
    logic signed [10:0] s;
    s = $signed({tot[9], tot}) + $signed({{3{d[7]}}, d});
    if (s > 11'sd511)       return 10'h1FF;
    else if (s < -11'sd512) return 10'h200;
    else                    return s[9:0];
  endfunction

endpackage

// File: rtl/bell_rule_check.sv
// Card rule: same colour needs n1+n2==5, otherwise any card showing 5.
module bell_rule_check (
  input  logic [1:0] i_c1,
  input  logic [1:0] i_c2,
  input  logic [2:0] i_n1,
  input  logic [2:0] i_n2,
  output logic       o_right_c
);

  logic [3:0] w_sum;

  assign w_sum     = 4'(i_n1) + 4'(i_n2);
  assign o_right_c = (i_c1 == i_c2) ? (w_sum == 4'd5)
                                    : ((i_n1 == 3'd5) || (i_n2 == 3'd5));

endmodule

// File: rtl/bell_round_ctrl.sv
// Round sequencer and bell arbiter for the two-player bell game.
// EARLY_WIN_EN: end the game after a gap once the score lead exceeds LEAD.
module bell_round_ctrl
  import bell_pkg::*;
#(
  parameter int unsigned ROUNDS     = 16,
  parameter int unsigned WINDOW     = 200,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned LEAD       = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       press1,
  input  logic       press2,
  output logic [1:0] c1,
  output logic [1:0] c2,
  output logic [2:0] n1,
  output logic [2:0] n2,
  output logic [7:0] count,
  output logic       add_valid,
  output logic [7:0] add1,
  output logic [7:0] add2,
  output logic [9:0] total1,
  output logic [9:0] total2,
  output logic [7:0] round_cnt,
  output logic       game_over,
  output logic [1:0] winner
);

`ifdef EARLY_WIN_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  state_t      r_state;
  logic [15:0] r_lfsr;
  logic        r_p1_prev;
  logic        r_p2_prev;
  logic        r_prio;
  logic [1:0]  r_who;
  logic [7:0]  r_gap;

  logic               w_e1;
  logic               w_e2;
  logic               w_fb;
  logic               w_right;
  logic signed [10:0] w_diff;
  logic [10:0]        w_diff_abs;
  logic               w_lead_hit;
  logic [1:0]         w_winner;

  assign w_e1 = press1 & ~r_p1_prev;
  assign w_e2 = press2 & ~r_p2_prev;
  assign w_fb = ^(r_lfsr & LFSR_TAPS);

  assign w_diff     = $signed({total1[9], total1}) - $signed({total2[9], total2});
  assign w_diff_abs = w_diff[10] ? 11'(-w_diff) : 11'(w_diff);
  assign w_lead_hit = EARLY_EN && (w_diff_abs > 11'(LEAD));

  assign w_winner = ($signed(total1) > $signed(total2)) ? P1 :
                    ($signed(total2) > $signed(total1)) ? P2 : P_NONE;

  bell_rule_check u_rule (
    .i_c1      (c1),
    .i_c2      (c2),
    .i_n1      (n1),
    .i_n2      (n2),
    .o_right_c (w_right)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lfsr    <= LFSR_SEED;
      r_p1_prev <= 1'b0;
      r_p2_prev <= 1'b0;
      r_prio    <= 1'b0;
      r_who     <= P_NONE;
      r_gap     <= 8'd0;
      c1        <= 2'd0;
      c2        <= 2'd0;
      n1        <= 3'd1;
      n2        <= 3'd1;
      count     <= 8'd0;
      add_valid <= 1'b0;
      add1      <= 8'd0;
      add2      <= 8'd0;
      total1    <= 10'd0;
      total2    <= 10'd0;
      round_cnt <= 8'd0;
      game_over <= 1'b0;
      winner    <= P_NONE;
    end else begin
      r_lfsr    <= {r_lfsr[14:0], w_fb};
      r_p1_prev <= press1;
      r_p2_prev <= press2;
      case (r_state)
        S_IDLE, S_OVER: begin
          if (start) begin
            total1    <= 10'd0;
            total2    <= 10'd0;
            round_cnt <= 8'd0;
            game_over <= 1'b0;
            winner    <= P_NONE;
            r_prio    <= 1'b0;
            r_state   <= S_DEAL;
          end
        end
        S_DEAL: begin
          c1      <= r_lfsr[1:0];
          c2      <= r_lfsr[9:8];
          n1      <= card_num(r_lfsr[4:2]);
          n2      <= card_num(r_lfsr[12:10]);
          count   <= 8'(WINDOW);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // count is frozen on a press and becomes the reward in JUDGE
          if (w_e1 && w_e2) begin
            r_who   <= r_prio ? P2 : P1;
            r_prio  <= ~r_prio;
            r_state <= S_JUDGE;
          end else if (w_e1) begin
            r_who   <= P1;
            r_state <= S_JUDGE;
          end else if (w_e2) begin
            r_who   <= P2;
            r_state <= S_JUDGE;
          end else if (count == 8'd0) begin
            add1      <= 8'd0;
            add2      <= 8'd0;
            add_valid <= 1'b1;
            r_state   <= S_SCORE;
          end else begin
            count <= count - 8'd1;
          end
        end
        S_JUDGE: begin
          add_valid <= 1'b1;
          if (w_right) begin
            add1 <= (r_who == P1) ? count : 8'd0;
            add2 <= (r_who == P2) ? count : 8'd0;
          end else begin
            add1 <= (r_who == P1) ? 8'hFF : 8'h01;
            add2 <= (r_who == P1) ? 8'h01 : 8'hFF;
          end
          r_state <= S_SCORE;
        end
        S_SCORE: begin
          add_valid <= 1'b0;
          total1    <= sat_add(total1, add1);
          total2    <= sat_add(total2, add2);
          round_cnt <= round_cnt + 8'd1;
          r_gap     <= 8'(GAP_CYCLES - 1);
          r_state   <= S_GAP;
        end
        S_GAP: begin
          if (r_gap == 8'd0) begin
            if ((round_cnt == 8'(ROUNDS)) || w_lead_hit) begin
              game_over <= 1'b1;
              winner    <= w_winner;
              r_state   <= S_OVER;
            end else begin
              r_state <= S_DEAL;
            end
          end else begin
            r_gap <= r_gap - 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
